// File: rtl/lstm_cell_state_update.sv
// LSTM cell-state update c_t = f*c_prev + i*g with an internal c_prev buffer and a fixed 4-stage pipeline.
// Optional build macro LSTM_CELL_ROUND_EN: round half up before the FRAC shift (default build truncates).
module lstm_cell_state_update #(
    parameter int INT_BITS   = 4,
    parameter int HIDDEN_NUM = 32,
    parameter int IDX_W      = $clog2(HIDDEN_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             seq_start,
    input  logic [15:0]      f_data,
    input  logic [15:0]      i_data,
    input  logic [15:0]      g_data,
    output logic             out_vld,
    output logic [15:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             step_done
);

    localparam int FRAC = 16 - INT_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HIDDEN_NUM - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(0);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
`ifdef LSTM_CELL_ROUND_EN
    localparam logic signed [32:0] RND_BIAS = 33'sd1 <<< (FRAC - 1);
`endif

    function automatic logic [15:0] sat16(input logic signed [32:0] v);
        logic [15:0] r;
        if (v > 33'sd32767) begin
            r = 16'h7FFF;
        end else if (v < -33'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    logic [IDX_W-1:0]   widx_r;
    logic               zero_step_r;
    logic [IDX_W-1:0]   idx_s;
    logic               zs_s;
    logic [IDX_W-1:0]   widx_nxt_s;
    logic               zero_step_nxt_s;

    logic signed [15:0] mem_r [HIDDEN_NUM];

    logic               s1_vld_r;
    logic [IDX_W-1:0]   s1_idx_r;
    logic signed [15:0] s1_f_r;
    logic signed [15:0] s1_i_r;
    logic signed [15:0] s1_g_r;
    logic signed [15:0] s1_cprev_r;

    logic               s2_vld_r;
    logic [IDX_W-1:0]   s2_idx_r;
    logic signed [31:0] s2_p1_r;
    logic signed [31:0] s2_p2_r;

    logic               s3_vld_r;
    logic [IDX_W-1:0]   s3_idx_r;
    logic signed [32:0] s3_sum_r;

    logic signed [32:0] sum_adj_s;
    logic signed [32:0] shifted_s;
    logic [15:0]        c_t_s;

    logic               out_vld_r;
    logic [15:0]        out_data_r;
    logic [IDX_W-1:0]   out_idx_r;
    logic               step_done_r;

    // Element index and zero_step resolution for the incoming element, plus next counter state
    always_comb begin
        idx_s           = widx_r;
        zs_s            = zero_step_r;
        widx_nxt_s      = widx_r;
        zero_step_nxt_s = zero_step_r;
        if (in_vld) begin
            // seq_start resyncs: the element becomes idx 0 of a step with no history
            if (seq_start) begin
                idx_s = ZERO_IDX;
                zs_s  = 1'b1;
            end else begin
                idx_s = widx_r;
                zs_s  = zero_step_r;
            end
            if (idx_s == LAST_IDX) begin
                widx_nxt_s      = ZERO_IDX;
                zero_step_nxt_s = 1'b0;
            end else begin
                widx_nxt_s      = idx_s + ONE_IDX;
                zero_step_nxt_s = zs_s;
            end
        end else begin
            widx_nxt_s      = widx_r;
            zero_step_nxt_s = zero_step_r;
        end
    end

    // Write index counter and zero_step flag
    always_ff @(posedge clk) begin
        if (rst) begin
            widx_r      <= ZERO_IDX;
            zero_step_r <= 1'b1;
        end else begin
            widx_r      <= widx_nxt_s;
            zero_step_r <= zero_step_nxt_s;
        end
    end

    // Four-stage datapath: capture/read, multiply, add, shift-saturate-output
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r    <= 1'b0;
            s1_idx_r    <= ZERO_IDX;
            s1_f_r      <= 16'sd0;
            s1_i_r      <= 16'sd0;
            s1_g_r      <= 16'sd0;
            s1_cprev_r  <= 16'sd0;
            s2_vld_r    <= 1'b0;
            s2_idx_r    <= ZERO_IDX;
            s2_p1_r     <= 32'sd0;
            s2_p2_r     <= 32'sd0;
            s3_vld_r    <= 1'b0;
            s3_idx_r    <= ZERO_IDX;
            s3_sum_r    <= 33'sd0;
            out_vld_r   <= 1'b0;
            out_data_r  <= 16'h0000;
            out_idx_r   <= ZERO_IDX;
            step_done_r <= 1'b0;
        end else begin
            s1_vld_r <= in_vld;
            if (in_vld) begin
                s1_idx_r   <= idx_s;
                s1_f_r     <= f_data;
                s1_i_r     <= i_data;
                s1_g_r     <= g_data;
                s1_cprev_r <= zs_s ? 16'sd0 : mem_r[idx_s];
            end
            s2_vld_r <= s1_vld_r;
            s2_idx_r <= s1_idx_r;
            s2_p1_r  <= 32'(s1_f_r) * 32'(s1_cprev_r);
            s2_p2_r  <= 32'(s1_i_r) * 32'(s1_g_r);
            s3_vld_r <= s2_vld_r;
            s3_idx_r <= s2_idx_r;
            s3_sum_r <= 33'(s2_p1_r) + 33'(s2_p2_r);
            out_vld_r   <= s3_vld_r;
            step_done_r <= s3_vld_r && (s3_idx_r == LAST_IDX);
            if (s3_vld_r) begin
                out_data_r <= c_t_s;
                out_idx_r  <= s3_idx_r;
            end
        end
    end

`ifdef LSTM_CELL_ROUND_EN
    assign sum_adj_s = s3_sum_r + RND_BIAS;
`else
    assign sum_adj_s = s3_sum_r;
`endif
    assign shifted_s = sum_adj_s >>> FRAC;
    assign c_t_s     = sat16(shifted_s);

    // c_t write-back; a same-index read is always at least HIDDEN_NUM cycles away, so no bypass
    always_ff @(posedge clk) begin
        if (!rst && s3_vld_r) begin
            mem_r[s3_idx_r] <= c_t_s;
        end
    end

    assign out_vld   = out_vld_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign step_done = step_done_r;

endmodule

// File: tb/tb_lstm_cell_state_update.sv
// Directed bench for lstm_cell_state_update (HIDDEN_NUM=4, Q3.12); outputs are collected by a
// monitor and checked against hand-computed values, including the 4-cycle input-to-output latency.
module tb_lstm_cell_state_update;

    localparam int HN = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic          seq_start;
    logic [15:0]   f_data;
    logic [15:0]   i_data;
    logic [15:0]   g_data;
    logic          out_vld;
    logic [15:0]   out_data;
    logic [IW-1:0] out_idx;
    logic          step_done;

    lstm_cell_state_update #(
        .INT_BITS   (4),
        .HIDDEN_NUM (HN),
        .IDX_W      (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .seq_start (seq_start),
        .f_data    (f_data),
        .i_data    (i_data),
        .g_data    (g_data),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .step_done (step_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0]   q_data [$];
    logic [IW-1:0] q_idx  [$];
    logic          q_done [$];
    int            q_cyc  [$];
    int            in_q   [$];

    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk) begin
        if (out_vld === 1'b1) begin
            q_data.push_back(out_data);
            q_idx.push_back(out_idx);
            q_done.push_back(step_done);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] f, input logic [15:0] i, input logic [15:0] g, input logic ss);
        @(negedge clk);
        in_vld    = 1'b1;
        seq_start = ss;
        f_data    = f;
        i_data    = i;
        g_data    = g;
        in_q.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_vld    = 1'b0;
            seq_start = 1'b0;
        end
    endtask

    task automatic step4(input logic [15:0] f, input logic [15:0] i, input logic [15:0] g, input logic ss);
        for (int k = 0; k < HN; k++) send(f, i, g, (k == 0) ? ss : 1'b0);
    endtask

    task automatic expect_out(input string tag, input logic [15:0] d, input int idx, input logic done);
        logic [15:0]   od;
        logic [IW-1:0] oi;
        logic          odn;
        int            oc;
        int            ic;
        chk({tag, "_vld"}, 32'(q_data.size() != 0), 32'd1);
        if (q_data.size() != 0) begin
            od  = q_data.pop_front();
            oi  = q_idx.pop_front();
            odn = q_done.pop_front();
            oc  = q_cyc.pop_front();
            chk({tag, "_data"}, 32'(od), 32'(d));
            chk({tag, "_idx"}, 32'(oi), 32'(idx));
            chk({tag, "_done"}, 32'(odn), 32'(done));
            if (in_q.size() != 0) begin
                ic = in_q.pop_front();
                chk({tag, "_lat"}, 32'(oc - ic), 32'd4);
            end
        end
    endtask

    task automatic expect_step(input string tag, input logic [15:0] d);
        for (int k = 0; k < HN; k++) expect_out(tag, d, k, k == HN - 1);
    endtask

    initial begin
        logic [15:0] rnd_exp;
        rst       = 1'b1;
        in_vld    = 1'b0;
        seq_start = 1'b0;
        f_data    = 16'h0000;
        i_data    = 16'h0000;
        g_data    = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_step_done", 32'(step_done), 32'd0);
        rst = 1'b0;

        // basic: 0.25 then 0.5*0.25+0.25
        step4(16'h0800, 16'h1000, 16'h0400, 1'b1);
        step4(16'h0800, 16'h1000, 16'h0400, 1'b0);
        idle(8);
        expect_step("basic1", 16'h0400);
        expect_step("basic2", 16'h0600);

        // positive and negative saturation
        step4(16'h1000, 16'h1000, 16'h7000, 1'b1);
        step4(16'h1000, 16'h1000, 16'h7000, 1'b0);
        idle(8);
        expect_step("satp1", 16'h7000);
        expect_step("satp2", 16'h7FFF);
        step4(16'h1000, 16'h1000, 16'h8000, 1'b1);
        step4(16'h1000, 16'h1000, 16'h8000, 1'b0);
        idle(8);
        expect_step("satn1", 16'h8000);
        expect_step("satn2", 16'h8000);

        // gaps: 1-0-1-0 input pattern, per-index distinct data
        for (int k = 0; k < HN; k++) begin
            send(16'h0000, 16'h1000, 16'((k + 1) * 256), k == 0);
            idle(1);
        end
        idle(8);
        for (int k = 0; k < HN; k++) expect_out("gap", 16'((k + 1) * 256), k, k == HN - 1);

        // resync at element 2 of a step that has history 0x0300
        step4(16'h0000, 16'h1000, 16'h0300, 1'b1);
        send(16'h1000, 16'h1000, 16'h0100, 1'b0);
        send(16'h1000, 16'h1000, 16'h0100, 1'b0);
        step4(16'h1000, 16'h1000, 16'h0100, 1'b1);
        step4(16'h1000, 16'h1000, 16'h0100, 1'b0);
        idle(8);
        expect_step("prefill", 16'h0300);
        expect_out("pre_resync0", 16'h0400, 0, 1'b0);
        expect_out("pre_resync1", 16'h0400, 1, 1'b0);
        expect_step("resync", 16'h0100);
        expect_step("post_resync", 16'h0200);

        // rounding: 0x0800 * 2^-12 -> 0.5 LSB
`ifdef LSTM_CELL_ROUND_EN
        rnd_exp = 16'h0001;
`else
        rnd_exp = 16'h0000;
`endif
        step4(16'h0000, 16'h1000, 16'h0800, 1'b1);
        step4(16'h0001, 16'h0000, 16'h0000, 1'b0);
        idle(8);
        expect_step("rnd1", 16'h0800);
        expect_step("rnd2", rnd_exp);

        // reset two cycles after idx 1: in-flight elements dropped, history cleared
        step4(16'h0000, 16'h1000, 16'h0500, 1'b1);
        idle(8);
        expect_step("prerst", 16'h0500);
        send(16'h1000, 16'h1000, 16'h0100, 1'b0);
        send(16'h1000, 16'h1000, 16'h0100, 1'b0);
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_q.delete();
        idle(8);
        chk("rst_drop", 32'(q_data.size()), 32'd0);
        step4(16'h1000, 16'h1000, 16'h0100, 1'b0);
        idle(8);
        expect_step("after_rst", 16'h0100);
        chk("tail_empty", 32'(q_data.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lstm_cell_state_update.md
Name: lstm_cell_state_update

Overview:
- Downstream consumer of the hard-sigmoid gate outputs in the LSTM datapath.
- Per hidden unit k, computes the new cell state c_t[k] = f[k]*c_{t-1}[k] + i[k]*g[k].
- Keeps c_{t-1} for all hidden units in an internal buffer and writes c_t back each time step.
- Feeds the tanh / output-gate stage with c_t in the same 16-bit fixed-point format.

Parameters:
- INT_BITS, 4, integer bits incl. sign of the Q format; FRAC = 16-INT_BITS (default Q(1,3,12), 1.0 = 0x1000).
- HIDDEN_NUM, 32, hidden units per time step; must be >= 4.
- IDX_W, $clog2(HIDDEN_NUM), width of the element index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_vld  in  1  f/i/g data valid for the current element
- seq_start  in  1  first element of a new sequence; sampled only when in_vld=1
- f_data  in  16  forget gate (hard-sigmoid output), signed Q format
- i_data  in  16  input gate (hard-sigmoid output), signed Q format
- g_data  in  16  candidate (tanh output), signed Q format
- out_vld  out  1  c_t valid
- out_data  out  16  c_t, signed Q format
- out_idx  out  IDX_W  hidden-unit index of out_data
- step_done  out  1  one-cycle pulse with the last element (idx HIDDEN_NUM-1) of a step

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- No backpressure. Elements arrive in index order 0..HIDDEN_NUM-1, one per in_vld cycle. Gaps (in_vld=0) are allowed anywhere.
- Write index counter:
  - increments on each in_vld;
  - wraps HIDDEN_NUM-1 -> 0;
  - forced to 0 (element taken as idx 0) when in_vld & seq_start, including mid-step (resync).
- zero_step flag:
  - set by rst and by in_vld & seq_start;
  - cleared when the element with idx HIDDEN_NUM-1 is accepted;
  - while set, c_{t-1} is treated as 0, regardless of buffer contents.
- Pipeline, fixed latency 4 cycles (in_vld at cycle N -> out_vld at N+4):
  - S1: register f, i, g and idx; read c_prev from the buffer (or force 0).
  - S2: two signed 16x16 -> 32-bit products, p1 = f*c_prev and p2 = i*g.
  - S3: 33-bit signed sum p1+p2.
  - S4: arithmetic shift right by FRAC (truncate toward -inf); saturate to 16 bits, >0x7FFF -> 0x7FFF, <-0x8000 -> 0x8000; register out_data; write c_t to the buffer at idx.
- Buffer: HIDDEN_NUM x 16, single write port and single read port.
  - Read and write of the same idx are never closer than HIDDEN_NUM >= 4 cycles, so no bypass is needed.
  - Contents are not reset.
- step_done is asserted in the same cycle as out_vld for out_idx = HIDDEN_NUM-1.
- Reset values: out_vld=0, out_data=0, out_idx=0, step_done=0, all pipeline valids=0, index counter=0, zero_step=1.
- Reset mid-operation: all in-flight elements are dropped; no out_vld follows reset.

Optional Feature:
- Macro: LSTM_CELL_ROUND_EN.
- Defined: S4 adds 2^(FRAC-1) to the 33-bit sum before the shift (round half up), then saturates. Latency is unchanged.
- Undefined: plain truncation as above.

Test Plan:
- Basic, HIDDEN_NUM=4, INT_BITS=4: seq_start with element 0; all 4 elements f=0x0800, i=0x1000, g=0x0400.
  -> out_data=0x0400 for idx 0..3; first out_vld 4 cycles after the first in_vld; step_done with idx 3.
  - Second step, same inputs -> out_data=0x0600 (0.5*0.25+0.25) for all idx.
- Saturation:
  - Positive: step 1 f=0x1000, i=0x1000, g=0x7000 -> 0x7000; step 2 same inputs -> 0x7FFF.
  - Negative: g=0x8000 for two steps -> 0x8000 both steps.
- Gaps and resync:
  - in_vld toggled 1-0-1-0 -> outputs keep the 4-cycle spacing of their inputs; idx is continuous.
  - seq_start asserted at element 2 -> that element becomes idx 0; c_prev is forced 0 until the step wraps.
- Rounding: step 1 f=0, i=0x1000, g=0x0800 (c=0x0800); step 2 f=0x0001, i=0, g=0.
  -> out_data=0x0000 without LSTM_CELL_ROUND_EN; 0x0001 with it.
- Reset mid-step: rst pulsed 2 cycles after in_vld of idx 1.
  -> no out_vld for the dropped elements; the next step (no seq_start) uses c_prev=0 and starts at idx 0.
